// File: rtl/btn_pkg.sv
// Shared constants and types for the push-button front-end.
// The timing defaults assume a 100 MHz system clock.
package btn_pkg;

  localparam int DEBOUNCE_10MS      = 1_000_000;
  localparam int REPEAT_DELAY_500MS = 50_000_000;
  localparam int REPEAT_RATE_150MS  = 15_000_000;

  localparam int BTN_NEXT = 0;
  localparam int BTN_PREV = 1;
  localparam int BTN_STEP = 2;
  localparam int BTN_EXEC = 3;
  localparam int BTN_CLR  = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESSED,
    REPEATING
  } rpt_state_t;

  // Width of a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchroniser, counter debounce, and the press /
// auto-repeat / release pulse FSM.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int REPEAT_RATE     = REPEAT_RATE_150MS,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam int RW = cnt_w(max2(REPEAT_DELAY, REPEAT_RATE));

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

  logic          s1, s2;
  logic          stable, stable_d;
  logic [DW-1:0] cnt, cnt_d;
  logic [RW-1:0] rcnt, rcnt_d;
  rpt_state_t    state, state_d;
  logic          pulse_d, release_d;
  logic          rise, fall;

  // Synchroniser: nothing but two flops, only s2 is consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // Debounce: any sample matching the accepted level restarts the count.
  always_comb begin
    stable_d = stable;
    cnt_d    = '0;
    rise     = 1'b0;
    fall     = 1'b0;
    if (s2 != stable) begin
      if (cnt == DB_LAST) begin
        stable_d = s2;
        rise     = s2;
        fall     = ~s2;
      end else begin
        cnt_d = cnt + 1'b1;
      end
    end
  end

  // Release wins over everything so a pending repeat never fires on the fall.
  always_comb begin
    state_d   = state;
    rcnt_d    = rcnt;
    pulse_d   = 1'b0;
    release_d = 1'b0;
    if (fall) begin
      state_d   = IDLE;
      rcnt_d    = '0;
      release_d = 1'b1;
    end else if (rise) begin
      state_d = PRESSED;
      rcnt_d  = '0;
      pulse_d = 1'b1;
    end else begin
      case (state)
        PRESSED: begin
          // Masked channels park at DLY_LAST until release.
          if (rcnt == DLY_LAST) begin
            if (REPEAT_EN) begin
              pulse_d = 1'b1;
              state_d = REPEATING;
              rcnt_d  = '0;
            end
          end else begin
            rcnt_d = rcnt + 1'b1;
          end
        end
        REPEATING: begin
          if (rcnt == RATE_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt + 1'b1;
          end
        end
        default: rcnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable      <= 1'b0;
      cnt         <= '0;
      state       <= IDLE;
      rcnt        <= '0;
      btn_pulse   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      stable      <= stable_d;
      cnt         <= cnt_d;
      state       <= state_d;
      rcnt        <= rcnt_d;
      btn_pulse   <= pulse_d;
      btn_release <= release_d;
    end
  end

  assign btn_level = stable;

endmodule

// File: rtl/button_conditioner.sv
// Board push-button front-end: N_BTN independent conditioned channels
// feeding the processor controller's one-cycle button strobes.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int               N_BTN           = 5,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_10MS,
  parameter int               REPEAT_DELAY    = REPEAT_DELAY_500MS,
  parameter int               REPEAT_RATE     = REPEAT_RATE_150MS,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(5'b00011)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] btn_release
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .REPEAT_EN      (REPEAT_MASK[i])
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_in     (btn_in[i]),
      .btn_level  (btn_level[i]),
      .btn_pulse  (btn_pulse[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: event-level model checked every cycle,
// plus hand-computed pulse/release timings per scenario.
module tb_button_conditioner;

  localparam int N    = 5;
  localparam int D    = 4;
  localparam int DLY  = 10;
  localparam int RATE = 3;
  localparam logic [N-1:0] MASK = 5'b00001;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_pulse, btn_release;

  int ntests = 0;
  int nfail  = 0;

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (DLY),
    .REPEAT_RATE    (RATE),
    .REPEAT_MASK    (MASK)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Model: input seen by the debouncer is the pin two edges back (zero if
  // that sample predates a reset); level flips after D consecutive
  // disagreeing observations; pulses are timed from the press edge.
  int           ecnt = 0;
  int           last_edge = -1;
  int           last_rst = -100;
  logic [N-1:0] smp [0:2047];
  logic [N-1:0] m_level = '0, m_pulse = '0, m_rel = '0;
  int           run [N];
  int           press_t [N];
  logic         seen;
  int           tp;

  always @(posedge clk) begin
    if (reset) begin
      last_rst = ecnt;
      m_level  = '0;
      m_pulse  = '0;
      m_rel    = '0;
      for (int c = 0; c < N; c++) run[c] = 0;
    end else begin
      for (int c = 0; c < N; c++) begin
        seen = (ecnt >= 2 && ecnt - 2 > last_rst) ? smp[ecnt-2][c] : 1'b0;
        m_pulse[c] = 1'b0;
        m_rel[c]   = 1'b0;
        if (seen != m_level[c]) run[c]++;
        else run[c] = 0;
        if (run[c] == D) begin
          run[c]     = 0;
          m_level[c] = ~m_level[c];
          if (m_level[c]) begin
            press_t[c] = ecnt;
            m_pulse[c] = 1'b1;
          end else begin
            m_rel[c] = 1'b1;
          end
        end else if (m_level[c] && MASK[c]) begin
          tp = ecnt - press_t[c];
          if (tp >= DLY && (tp - DLY) % RATE == 0) m_pulse[c] = 1'b1;
        end
      end
    end
    smp[ecnt] = btn_in;
    last_edge = ecnt;
    ecnt++;
  end

  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s after edge %0d: got %b expected %b", nm, last_edge, act, exp);
    end
  endtask

  int plog [N][$];
  int rlog [N][$];

  always @(posedge clk) begin
    #1;
    if (last_edge >= 0) begin
      chk("level", btn_level, m_level);
      chk("pulse", btn_pulse, m_pulse);
      chk("release", btn_release, m_rel);
      chk("pulse_and_release", btn_pulse & btn_release, '0);
      for (int c = 0; c < N; c++) begin
        if (btn_pulse[c]) plog[c].push_back(last_edge);
        if (btn_release[c]) rlog[c].push_back(last_edge);
      end
    end
  end

  // Compare the logged event edges (relative to base) in a window against expq.
  int expq[$];
  task automatic check_log(input string nm, input int c, input bit is_rel, input int base,
                           input int span);
    int    got[$];
    int    n, v;
    bit    ok;
    string sg, se;
    n = is_rel ? rlog[c].size() : plog[c].size();
    for (int k = 0; k < n; k++) begin
      v = is_rel ? rlog[c][k] : plog[c][k];
      if (v >= base && v < base + span) got.push_back(v - base);
    end
    ok = (got.size() == expq.size());
    if (ok) for (int k = 0; k < got.size(); k++) if (got[k] != expq[k]) ok = 1'b0;
    ntests++;
    if (!ok) begin
      nfail++;
      sg = "";
      se = "";
      foreach (got[k]) sg = {sg, $sformatf(" %0d", got[k])};
      foreach (expq[k]) se = {se, $sformatf(" %0d", expq[k])};
      $display("FAIL %s ch%0d: got edges [%s ] expected [%s ]", nm, c, sg, se);
    end
  endtask

  logic [19:0] pat = 20'b1111_1111_1111_0011_0011;
  int b;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_level", btn_level, '0);
    chk("reset_pulse", btn_pulse, '0);
    chk("reset_release", btn_release, '0);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press on channel 2 (no repeat)
    b = ecnt;
    btn_in[2] = 1'b1;
    repeat (8) @(negedge clk);
    btn_in[2] = 1'b0;
    repeat (12) @(negedge clk);
    expq = {5};
    check_log("clean_pulse", 2, 1'b0, b, 20);
    expq = {13};
    check_log("clean_release", 2, 1'b1, b, 20);

    // Bouncing press on channel 3
    b = ecnt;
    for (int i = 0; i < 20; i++) begin
      btn_in[3] = pat[i];
      @(negedge clk);
    end
    btn_in[3] = 1'b0;
    repeat (12) @(negedge clk);
    expq = {13};
    check_log("bounce_pulse", 3, 1'b0, b, 32);
    expq = {25};
    check_log("bounce_release", 3, 1'b1, b, 32);

    // Auto-repeat on channel 0; the repeat due at 33 is cancelled by release
    b = ecnt;
    btn_in[0] = 1'b1;
    repeat (28) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (14) @(negedge clk);
    expq = {5, 15, 18, 21, 24, 27, 30};
    check_log("repeat_pulses", 0, 1'b0, b, 42);
    expq = {33};
    check_log("repeat_release", 0, 1'b1, b, 42);

    // Glitch on channel 1 shorter than debounce window
    b = ecnt;
    btn_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    btn_in[1] = 1'b0;
    repeat (10) @(negedge clk);
    expq = {};
    check_log("glitch_pulse", 1, 1'b0, b, 13);
    check_log("glitch_release", 1, 1'b1, b, 13);

    // Simultaneous press on channels 0 and 4
    b = ecnt;
    btn_in[0] = 1'b1;
    btn_in[4] = 1'b1;
    repeat (8) @(negedge clk);
    btn_in[0] = 1'b0;
    btn_in[4] = 1'b0;
    repeat (12) @(negedge clk);
    expq = {5};
    check_log("simul_pulse0", 0, 1'b0, b, 20);
    check_log("simul_pulse4", 4, 1'b0, b, 20);

    // Reset pulsed at edge 12 while channel 0 is held
    b = ecnt;
    btn_in[0] = 1'b1;
    repeat (12) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_level", btn_level, '0);
    chk("rst_mid_pulse", btn_pulse, '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (23) @(negedge clk);
    btn_in[0] = 1'b0;
    repeat (10) @(negedge clk);
    expq = {5, 18, 28, 31, 34, 37, 40};
    check_log("rstmid_pulses", 0, 1'b0, b, 46);
    expq = {41};
    check_log("rstmid_release", 0, 1'b1, b, 46);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
